reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
Shares the single write port of the register file between two writeback requesters: requester 0 is ALU writeback and requester 1 is load/mem writeback. Arbitration is round-robin, with a valid/ready handshake on each requester. Each accepted write is staged for one cycle and then driven onto the register-file write port. While the write sits in the stage, two forwarding query ports expose it, so combinational readers of the register file never see stale data.

Parameters:
DATA_WIDTH, 32, width of the register data word
ADDR_WIDTH, 5, width of the register index (2**ADDR_WIDTH registers)
CNT_WIDTH, 16, width of the per-requester accept counters

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  reset, asynchronous, active-low (rst==0 resets)
req0_valid  in  1  requester 0 has a write pending
req0_addr  in  ADDR_WIDTH  requester 0 destination register
req0_data  in  DATA_WIDTH  requester 0 write data
req0_ready  out  1  requester 0 accepted this cycle
req1_valid  in  1  requester 1 has a write pending
req1_addr  in  ADDR_WIDTH  requester 1 destination register
req1_data  in  DATA_WIDTH  requester 1 write data
req1_ready  out  1  requester 1 accepted this cycle
rf_wen  out  1  register-file write enable (registered)
rf_waddr  out  ADDR_WIDTH  register-file write address (registered)
rf_wdata  out  DATA_WIDTH  register-file write data (registered)
q_addr1  in  ADDR_WIDTH  forwarding query address, read port 1
q_hit1  out  1  staged write targets q_addr1
q_data1  out  DATA_WIDTH  staged data when q_hit1, else 0
q_addr2  in  ADDR_WIDTH  forwarding query address, read port 2
q_hit2  out  1  staged write targets q_addr2
q_data2  out  DATA_WIDTH  staged data when q_hit2, else 0
acc_cnt0  out  CNT_WIDTH  accepted-write count, requester 0 (saturating)
acc_cnt1  out  CNT_WIDTH  accepted-write count, requester 1 (saturating)

Behaviour:
- Reset (rst==0, asynchronous):
  - stg_valid=0, stg_addr=0, stg_data=0, so rf_wen=0, rf_waddr=0, rf_wdata=0 immediately.
  - last_grant=1, so requester 0 wins the first contest.
  - acc_cnt0=acc_cnt1=0.
  - A transfer granted in the cycle reset asserts is lost.
- Grant (combinational, at most one per cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the requester that is not last_grant.
  - reqN_ready = grant to N. Handshake completes when valid & ready are both high in the same cycle.
- Requester rule: a requester holds valid, addr and data stable until ready. The arbiter places no constraint on ready-before-valid.
- last_grant updates only on a completed grant. Idle cycles leave it unchanged.
- Stage: the write port always accepts, so the stage drains every cycle and never back-pressures.
  - On a grant with addr!=0: stage loads addr and data, stg_valid=1 in the next cycle.
  - On no grant: stg_valid=0 in the next cycle.
- Latency: accepted in cycle N → rf_wen=1 in cycle N+1 → register updated at the end of N+1.
- Writes to register 0: the handshake completes and the counter increments, but the stage is not loaded, so rf_wen=0 in the next cycle. Register 0 is never written.
- Forwarding (combinational):
  - q_hitK = stg_valid & (stg_addr==q_addrK) & (q_addrK!=0).
  - q_dataK = stg_data when q_hitK, else 0.
  - Both ports may hit simultaneously.
- Counters: accNcnt increments on each completed handshake of N and saturates at all-ones with no wrap.
- Back-to-back same address: two grants in consecutive cycles produce consecutive rf_wen pulses in grant order. The last grant wins in the register file.

Decomposition:
- Package reg_wb_pkg: DATA_WIDTH/ADDR_WIDTH defaults, grant encoding (GNT_NONE, GNT_0, GNT_1) and the register-0 constant.
- Sub-module rr_arb2: 2-way round-robin arbiter. It holds the last_grant flop and produces the one-hot grant from the two valids.
- Stage, forwarding and counters live in reg_wb_arbiter.

Test Plan:
- Reset release, then idle: rf_wen=0, q_hit1=q_hit2=0, acc_cnt0=acc_cnt1=0. Assert rst low mid-stream → rf_wen drops in the same cycle without waiting for clk.
- req0 only (addr 5, data 0xDEADBEEF) in cycle N → req0_ready=1 in N; in N+1 rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; acc_cnt0=1.
- Both valid for 4 cycles (req0 addr 1, req1 addr 2) from reset → grants 0,1,0,1; rf_waddr sequence 1,2,1,2 one cycle later; acc_cnt0=acc_cnt1=2.
- req1 addr 0, data 0x1234 → req1_ready=1, acc_cnt1 increments; next cycle rf_wen=0; a query with q_addr1=0 gives q_hit1=0.
- Grant req0 addr 7, data 0xA5 in N; in N+1 q_addr1=7, q_addr2=7 → q_hit1=q_hit2=1, q_data1=q_data2=0xA5. With q_addr2=8 instead → q_hit2=0, q_data2=0.
- req0 held valid for 65540 grants (req1 idle, CNT_WIDTH=16) → acc_cnt0 saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Grant codes are one-hot so bit N is directly requester N's ready.
package reg_wb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

    localparam int REG_ZERO = 0;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from two valids, with the
// last_grant flop deciding contested cycles.
module rr_arb2
    import reg_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] gnt
);
    logic last_grant;

    always_comb begin
        gnt = GNT_NONE;
        case (valid)
            2'b01:   gnt = GNT_0;
            2'b10:   gnt = GNT_1;
            2'b11:   gnt = last_grant ? GNT_0 : GNT_1;
            default: gnt = GNT_NONE;
        endcase
    end

    // Any grant implies valid&ready, so every grant is a completed handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= 1'b1;
        else if (gnt != GNT_NONE)
            last_grant <= gnt[1];
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin share of the register-file write port between ALU (0) and
// load (1) writeback, with a one-cycle stage that is forwarded to readers.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] q_addr1,
    output logic                  q_hit1,
    output logic [DATA_WIDTH-1:0] q_data1,
    input  logic [ADDR_WIDTH-1:0] q_addr2,
    output logic                  q_hit2,
    output logic [DATA_WIDTH-1:0] q_data2,
    output logic [CNT_WIDTH-1:0]  acc_cnt0,
    output logic [CNT_WIDTH-1:0]  acc_cnt1
);
    localparam logic [ADDR_WIDTH-1:0] R0 = ADDR_WIDTH'(REG_ZERO);

    logic [1:0]                 gnt;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic                       stg_load;
    logic                       stg_valid;
    logic [ADDR_WIDTH-1:0]      stg_addr;
    logic [DATA_WIDTH-1:0]      stg_data;
    logic [1:0][CNT_WIDTH-1:0]  cnt;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign wr_addr  = gnt[1] ? req1_addr : req0_addr;
    assign wr_data  = gnt[1] ? req1_data : req0_data;
    // Writes to register 0 complete the handshake but never reach the port.
    assign stg_load = (gnt != GNT_NONE) && (wr_addr != R0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_valid <= 1'b0;
            stg_addr  <= '0;
            stg_data  <= '0;
        end else begin
            stg_valid <= stg_load;
            if (stg_load) begin
                stg_addr <= wr_addr;
                stg_data <= wr_data;
            end
        end
    end

    assign rf_wen   = stg_valid;
    assign rf_waddr = stg_addr;
    assign rf_wdata = stg_data;

    assign q_hit1  = stg_valid && (stg_addr == q_addr1) && (q_addr1 != R0);
    assign q_hit2  = stg_valid && (stg_addr == q_addr2) && (q_addr2 != R0);
    assign q_data1 = q_hit1 ? stg_data : '0;
    assign q_data2 = q_hit2 ? stg_data : '0;

    for (genvar i = 0; i < 2; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                cnt[i] <= '0;
            else if (gnt[i] && (cnt[i] != {CNT_WIDTH{1'b1}}))
                cnt[i] <= cnt[i] + 1'b1;
        end
    end

    assign acc_cnt0 = cnt[0];
    assign acc_cnt1 = cnt[1];
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: inputs driven on the falling edge,
// combinational outputs checked before the rising edge, registered ones #1 after.
module tb_reg_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr, rf_waddr, q_addr1, q_addr2;
    logic [31:0] req0_data, req1_data, rf_wdata, q_data1, q_data2;
    logic        rf_wen, q_hit1, q_hit2;
    logic [15:0] acc_cnt0, acc_cnt1;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_addr1(q_addr1), .q_hit1(q_hit1), .q_data1(q_data1),
        .q_addr2(q_addr2), .q_hit2(q_hit2), .q_data2(q_data2),
        .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        q_addr1 = 0; q_addr2 = 0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", rf_wen, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        @(negedge clk);
        rst = 1'b1;
        q_addr1 = 5'd3; q_addr2 = 5'd5;
        tick();
        chk("idle_wen", rf_wen, 0);
        chk("idle_hit1", q_hit1, 0);
        chk("idle_hit2", q_hit2, 0);
        chk("idle_cnt0", acc_cnt0, 0);
        chk("idle_cnt1", acc_cnt1, 0);

        // single requester 0
        @(negedge clk);
        req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        chk("r0_ready", req0_ready, 1);
        chk("r0_ready1", req1_ready, 0);
        tick();
        req0_valid = 0;
        chk("r0_wen", rf_wen, 1);
        chk("r0_waddr", rf_waddr, 5);
        chk("r0_wdata", rf_wdata, 32'hDEADBEEF);
        chk("r0_cnt0", acc_cnt0, 1);
        chk("r0_fwd_hit2", q_hit2, 1);
        chk("r0_fwd_data2", q_data2, 32'hDEADBEEF);

        // asynchronous reset mid-stream, between clock edges
        rst = 1'b0;
        #1;
        chk("async_wen", rf_wen, 0);
        chk("async_cnt0", acc_cnt0, 0);
        @(negedge clk);
        rst = 1'b1;

        // both valid from reset: grants 0,1,0,1
        req0_valid = 1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_ready1", req1_ready, (k % 2 == 0) ? 0 : 1);
            tick();
            chk("rr_wen", rf_wen, 1);
            chk("rr_waddr", rf_waddr, (k % 2 == 0) ? 1 : 2);
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        chk("rr_cnt0", acc_cnt0, 2);
        chk("rr_cnt1", acc_cnt1, 2);

        // write to register 0 from requester 1
        req1_valid = 1; req1_addr = 5'd0; req1_data = 32'h1234;
        #1;
        chk("z_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        q_addr1 = 5'd0;
        #1;
        chk("z_wen", rf_wen, 0);
        chk("z_cnt1", acc_cnt1, 3);
        chk("z_hit1", q_hit1, 0);
        chk("z_data1", q_data1, 0);

        // forwarding on both ports, then a miss on port 2
        @(negedge clk);
        req0_valid = 1; req0_addr = 5'd7; req0_data = 32'hA5;
        #1;
        chk("f_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        q_addr1 = 5'd7; q_addr2 = 5'd7;
        #1;
        chk("f_hit1", q_hit1, 1);
        chk("f_hit2", q_hit2, 1);
        chk("f_data1", q_data1, 32'hA5);
        chk("f_data2", q_data2, 32'hA5);
        q_addr2 = 5'd8;
        #1;
        chk("f_miss_hit2", q_hit2, 0);
        chk("f_miss_data2", q_data2, 0);
        chk("f_keep_hit1", q_hit1, 1);

        // back-to-back same address, then idle, then a contest
        @(negedge clk);
        req0_valid = 1; req0_addr = 5'd9; req0_data = 32'h1;
        tick();
        chk("bb_first", rf_wdata, 32'h1);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_addr = 5'd9; req1_data = 32'h2;
        tick();
        chk("bb_wen", rf_wen, 1);
        chk("bb_addr", rf_waddr, 9);
        chk("bb_second", rf_wdata, 32'h2);
        @(negedge clk);
        req1_valid = 0;
        tick();
        chk("bb_drain_wen", rf_wen, 0);
        @(negedge clk);
        req0_valid = 1; req0_addr = 5'd3; req1_valid = 1; req1_addr = 5'd4;
        #1;
        // last grant was requester 1, idle cycles must not change that
        chk("idle_keep_r0", req0_ready, 1);
        chk("idle_keep_r1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;

        // saturation of acc_cnt0
        rst = 1'b0;
        #1;
        chk("sat_rst_cnt0", acc_cnt0, 0);
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1; req0_addr = 5'd6; req0_data = 32'h66;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", acc_cnt0, 16'hFFFE);
        tick();
        chk("sat_ffff", acc_cnt0, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_hold", acc_cnt0, 16'hFFFF);
        chk("sat_cnt1", acc_cnt1, 0);
        req0_valid = 0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
